// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the uart_tx_arb transmit scheduler.
package uart_arb_pkg;

   localparam int unsigned HOLD_CYCLES = 2;
   localparam logic [1:0]  HOLD_LAST   = 2'(HOLD_CYCLES - 1);

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      DRAIN
   } state_e;

endpackage

// File: rtl/sync_fifo8.sv
// Byte-wide synchronous FIFO with binary pointers carrying one extra wrap bit.
module sync_fifo8 #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [7:0]  mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   // Fullness is judged on the pre-pop pointers, so a push to a full FIFO
   // is dropped even when the same cycle pops it.
   always_comb begin
      full    = (wptr_q ^ rptr_q) == PTR_FULL;
      empty   = (wptr_q == rptr_q);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
      dout    = mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-source transmit scheduler feeding the single buart transmitter.
// Define UART_TX_ARB_PRIO_EN for strict A-over-B priority; default is round-robin.
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_wr,
   input  logic [7:0] a_data,
   output logic       a_full,
   output logic       a_ovf,
   input  logic       b_wr,
   input  logic [7:0] b_data,
   output logic       b_full,
   output logic       b_ovf,
   input  logic       ovf_clr,
   output logic       tx_wr,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       idle
);
   state_e     state_q, state_d;
   logic [1:0] hold_q, hold_d;
   logic       tx_wr_q, tx_wr_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       a_ovf_q, a_ovf_d;
   logic       b_ovf_q, b_ovf_d;
   logic       a_pop, b_pop;
   logic       a_empty, b_empty;
   logic [7:0] a_dout, b_dout;
   logic       sel;
`ifndef UART_TX_ARB_PRIO_EN
   logic       last_q, last_d;
`endif

   sync_fifo8 #(.DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .reset (reset),
      .push  (a_wr),
      .din   (a_data),
      .pop   (a_pop),
      .dout  (a_dout),
      .empty (a_empty),
      .full  (a_full)
   );

   sync_fifo8 #(.DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .reset (reset),
      .push  (b_wr),
      .din   (b_data),
      .pop   (b_pop),
      .dout  (b_dout),
      .empty (b_empty),
      .full  (b_full)
   );

   always_comb begin
      sel = SRC_A;
`ifdef UART_TX_ARB_PRIO_EN
      if (a_empty) sel = SRC_B;
`else
      if (a_empty) sel = SRC_B;
      else if (!b_empty && last_q == SRC_A) sel = SRC_B;
`endif
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      tx_wr_d   = 1'b0;
      tx_data_d = tx_data_q;
      a_pop     = 1'b0;
      b_pop     = 1'b0;
`ifndef UART_TX_ARB_PRIO_EN
      last_d    = last_q;
`endif
      a_ovf_d   = (a_ovf_q & ~ovf_clr) | (a_wr & a_full);
      b_ovf_d   = (b_ovf_q & ~ovf_clr) | (b_wr & b_full);

      case (state_q)
         IDLE: begin
            if (!tx_busy && (!a_empty || !b_empty)) begin
               a_pop     = (sel == SRC_A);
               b_pop     = (sel == SRC_B);
               tx_data_d = (sel == SRC_A) ? a_dout : b_dout;
               tx_wr_d   = 1'b1;
               hold_d    = '0;
               state_d   = HOLD;
`ifndef UART_TX_ARB_PRIO_EN
               last_d    = sel;
`endif
            end
         end
         // tx_busy is ignored here to ride out buart's busy-rise latency.
         HOLD: begin
            if (hold_q == HOLD_LAST) state_d = DRAIN;
            else                     hold_d  = hold_q + 2'd1;
         end
         DRAIN: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= '0;
         a_ovf_q   <= 1'b0;
         b_ovf_q   <= 1'b0;
`ifndef UART_TX_ARB_PRIO_EN
         last_q    <= SRC_B;
`endif
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         tx_wr_q   <= tx_wr_d;
         tx_data_q <= tx_data_d;
         a_ovf_q   <= a_ovf_d;
         b_ovf_q   <= b_ovf_d;
`ifndef UART_TX_ARB_PRIO_EN
         last_q    <= last_d;
`endif
      end
   end

   assign tx_wr   = tx_wr_q;
   assign tx_data = tx_data_q;
   assign a_ovf   = a_ovf_q;
   assign b_ovf   = b_ovf_q;
   assign idle    = a_empty & b_empty & (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table, directed corner cases and
// a randomized run against a queue-based reference model.
module tb_uart_tx_arb;
   localparam int DEPTH = 8;

   logic       clk;
   logic       reset;
   logic       a_wr, b_wr, ovf_clr, tx_busy;
   logic [7:0] a_data, b_data;
   logic       a_full, a_ovf, b_full, b_ovf, tx_wr, idle;
   logic [7:0] tx_data;

   int n_checks = 0;
   int n_fail   = 0;
   int got_q[$];
   int exp_q[$];

   uart_tx_arb #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_wr    (a_wr),
      .a_data  (a_data),
      .a_full  (a_full),
      .a_ovf   (a_ovf),
      .b_wr    (b_wr),
      .b_data  (b_data),
      .b_full  (b_full),
      .b_ovf   (b_ovf),
      .ovf_clr (ovf_clr),
      .tx_wr   (tx_wr),
      .tx_data (tx_data),
      .tx_busy (tx_busy),
      .idle    (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       a_wr;
      logic [7:0] a_data;
      logic       b_wr;
      logic [7:0] b_data;
      logic       clr;
      logic       busy;
      logic       e_wr;
      logic [7:0] e_data;
      logic       e_bfull;
      logic       e_bovf;
      logic       e_idle;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(logic aw, logic [7:0] ad, logic bw, logic [7:0] bd,
                               logic clr, logic busy, logic ewr, logic [7:0] ed,
                               logic ebf, logic ebo, logic eid);
      vec_t v;
      v.a_wr = aw; v.a_data = ad; v.b_wr = bw; v.b_data = bd;
      v.clr = clr; v.busy = busy; v.e_wr = ewr; v.e_data = ed;
      v.e_bfull = ebf; v.e_bovf = ebo; v.e_idle = eid;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_wr = 0; b_wr = 0; a_data = 0; b_data = 0; ovf_clr = 0; tx_busy = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Releases tx_busy, models buart busy (lat cycles after strobe, dur long) and
   // collects up to n strobed bytes. With data queued, the next strobe must land
   // max(4, lat+dur+2) cycles after the previous one.
   task automatic collect(input int n, input int lat, input int dur, input int budget,
                          input string tag);
      int bs, be, lastk, spacing;
      bs = -1; be = -2; lastk = -1;
      spacing = (lat + dur + 2 > 4) ? lat + dur + 2 : 4;
      got_q.delete();
      for (int c = 0; c < budget && got_q.size() < n; c++) begin
         if (tx_wr) begin
            got_q.push_back(int'(tx_data));
            if (lastk >= 0) chk({tag, "_spacing"}, c - lastk, spacing);
            lastk = c; bs = c + lat; be = c + lat + dur - 1;
         end
         tx_busy = (c >= bs && c <= be);
         @(negedge clk);
      end
      chk({tag, "_count"}, got_q.size(), n);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      tx_busy = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int c = 0; c < 40 && !idle; c++) @(negedge clk);
      chk({tag, "_idle"}, idle, 1);
   endtask

   task automatic run_random();
      int qa[$], qb[$];
      logic m_last, m_aovf, m_bovf, drop_a, drop_b, sel_b, prev_busy;
      logic p_aw, p_bw, p_clr;
      logic [7:0] p_ad, p_bd;
      int sa, sb, bs, be, last_k, ex, pa, pc;
      do_reset();
      m_last = 1'b1; m_aovf = 0; m_bovf = 0; prev_busy = 0;
      p_aw = 0; p_bw = 0; p_clr = 0; p_ad = 0; p_bd = 0;
      bs = -1; be = -2; last_k = -100;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         sa = qa.size(); sb = qb.size();
         if (tx_wr) begin
            if (sa + sb == 0) chk("rnd_unexpected_strobe", tx_wr, 0);
            else begin
               chk("rnd_issue_while_busy", tx_wr & prev_busy, 0);
               chk("rnd_spacing_ge4", (cyc - last_k) >= 4, 1);
`ifdef UART_TX_ARB_PRIO_EN
               sel_b = (sa == 0);
`else
               sel_b = (sa == 0) || (sb != 0 && m_last == 1'b0);
`endif
               ex = sel_b ? qb.pop_front() : qa.pop_front();
               m_last = sel_b;
               chk("rnd_tx_data", tx_data, ex);
            end
            last_k = cyc;
            bs = cyc + int'($urandom_range(0, 2));
            be = bs + int'($urandom_range(1, 8)) - 1;
         end
         drop_a = p_aw && sa == DEPTH;
         drop_b = p_bw && sb == DEPTH;
         if (p_aw && !drop_a) qa.push_back(int'(p_ad));
         if (p_bw && !drop_b) qb.push_back(int'(p_bd));
         m_aovf = (m_aovf & ~p_clr) | drop_a;
         m_bovf = (m_bovf & ~p_clr) | drop_b;
         chk("rnd_a_full", a_full, qa.size() == DEPTH);
         chk("rnd_b_full", b_full, qb.size() == DEPTH);
         chk("rnd_a_ovf", a_ovf, m_aovf);
         chk("rnd_b_ovf", b_ovf, m_bovf);
         if (qa.size() + qb.size() != 0) chk("rnd_idle_with_data", idle, 0);
         pa = (cyc < 600) ? 50 : (cyc < 1200) ? 15 : 0;
         pc = (cyc < 1200) ? 3 : 0;
         p_aw = ($urandom_range(0, 99) < pa);
         p_bw = ($urandom_range(0, 99) < pa);
         p_clr = ($urandom_range(0, 99) < pc);
         p_ad = 8'($urandom); p_bd = 8'($urandom);
         a_wr = p_aw; a_data = p_ad; b_wr = p_bw; b_data = p_bd; ovf_clr = p_clr;
         tx_busy = (cyc >= bs && cyc <= be);
         prev_busy = tx_busy;
         @(negedge clk);
      end
      chk("rnd_drained", qa.size() + qb.size(), 0);
      chk("rnd_final_idle", idle, 1);
   endtask

   initial begin
      int found, strobes;

      // Vector table: single byte on A, then B overflow with buart held busy.
      vt[0] = mk(1, 8'h41, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
      vt[1] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h41, 0, 0, 0);
      vt[2] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h41, 0, 0, 0);
      vt[3] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h41, 0, 0, 0);
      vt[4] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h41, 0, 0, 0);
      vt[5] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h41, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++)
         vt[6+i] = mk(0, 8'h00, 1, 8'(8'hB0 + i), 0, 1, 0, 8'h41, (i == DEPTH-1), 0, 0);
      vt[14] = mk(0, 8'h00, 1, 8'hFF, 0, 1, 0, 8'h41, 1, 1, 0);
      vt[15] = mk(0, 8'h00, 1, 8'hFE, 1, 1, 0, 8'h41, 1, 1, 0);
      vt[16] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 8'h41, 1, 0, 0);

      reset = 1'b1;
      a_wr = 0; b_wr = 0; a_data = 0; b_data = 0; ovf_clr = 0; tx_busy = 0;
      @(negedge clk);
      chk("rst_tx_wr", tx_wr, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_a_full", a_full, 0);
      chk("rst_b_full", b_full, 0);
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_b_ovf", b_ovf, 0);
      chk("rst_idle", idle, 1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         a_wr = vt[i].a_wr; a_data = vt[i].a_data;
         b_wr = vt[i].b_wr; b_data = vt[i].b_data;
         ovf_clr = vt[i].clr; tx_busy = vt[i].busy;
         @(negedge clk);
         chk($sformatf("vec%0d_tx_wr", i), tx_wr, vt[i].e_wr);
         chk($sformatf("vec%0d_tx_data", i), tx_data, vt[i].e_data);
         chk($sformatf("vec%0d_a_full", i), a_full, 0);
         chk($sformatf("vec%0d_b_full", i), b_full, vt[i].e_bfull);
         chk($sformatf("vec%0d_a_ovf", i), a_ovf, 0);
         chk($sformatf("vec%0d_b_ovf", i), b_ovf, vt[i].e_bovf);
         chk($sformatf("vec%0d_idle", i), idle, vt[i].e_idle);
      end
      b_wr = 0; ovf_clr = 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hB0 + i);
      collect(DEPTH, 1, 3, 400, "ovf_drain");
      wait_idle("ovf_drain");

      // Both sources loaded, buart busy for 10 cycles per byte.
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_wr = 1; a_data = 8'(8'h01 + i); b_wr = 1; b_data = 8'(8'h11 + i);
         @(negedge clk);
      end
      a_wr = 0; b_wr = 0;
`ifdef UART_TX_ARB_PRIO_EN
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
`else
      exp_q = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
`endif
      collect(6, 0, 10, 200, "order");
      wait_idle("order");

      // buart busy rises two cycles after the strobe.
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a_wr = 1; a_data = 8'(8'h21 + i);
         @(negedge clk);
      end
      a_wr = 0;
      exp_q = '{8'h21, 8'h22};
      collect(2, 2, 5, 100, "late_busy");
      wait_idle("late_busy");

      // Reset while draining with three bytes still queued.
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_wr = 1; a_data = 8'(8'h31 + i);
         @(negedge clk);
      end
      a_wr = 0; tx_busy = 0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge clk);
         if (tx_wr) found = 1;
      end
      chk("rst_mid_first_strobe", found, 1);
      tx_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_pre_idle", idle, 0);
      reset = 1'b1;
      #1;
      chk("rst_mid_tx_wr", tx_wr, 0);
      chk("rst_mid_idle", idle, 1);
      chk("rst_mid_tx_data", tx_data, 8'h00);
      @(negedge clk);
      chk("rst_mid_next_tx_wr", tx_wr, 0);
      chk("rst_mid_next_idle", idle, 1);
      reset = 1'b0; tx_busy = 1'b0;
      strobes = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tx_wr) strobes++;
      end
      chk("rst_mid_no_strobe", strobes, 0);
      chk("rst_mid_after_idle", idle, 1);

      run_random();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
